// File: rtl/comb_vec_checker.sv
// Clocked stimulus generator and checker for four implementations of one
// 4-input combinational function: sweeps all 16 vectors and records agreement.
module comb_vec_checker #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic [3:0]  Y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_bad_vec,
    output logic        first_bad_valid
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t     state, state_nx;
    logic [3:0] vec;
    logic [3:0] cnt;
    logic       y_disagree;

    // Case inequality so an x/z from any implementation also counts as a disagreement.
    assign y_disagree = (Y_in !== 4'b0000) && (Y_in !== 4'b1111);

    assign {A, B, C, D} = vec;
    assign busy         = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done         = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // NOTE: next-state is defaulted first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_SETTLE;
            ST_SETTLE: if (cnt == 4'd0) state_nx = ST_SAMPLE;
            ST_SAMPLE: state_nx = (vec == 4'd15) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec             <= 4'd0;
            cnt             <= 4'd0;
            truth           <= 16'd0;
            mismatch_count  <= 5'd0;
            first_bad_vec   <= 4'd0;
            first_bad_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec             <= 4'd0;
                        cnt             <= CNT_LOAD;
                        truth           <= 16'd0;
                        mismatch_count  <= 5'd0;
                        first_bad_vec   <= 4'd0;
                        first_bad_valid <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                ST_SAMPLE: begin
                    truth[vec] <= Y_in[0];
                    if (y_disagree) begin
                        mismatch_count <= mismatch_count + 5'd1;
                        if (!first_bad_valid) begin
                            first_bad_vec   <= vec;
                            first_bad_valid <= 1'b1;
                        end
                    end
                    // The last vector stays on A..D after the sweep.
                    if (vec != 4'd15) begin
                        vec <= vec + 4'd1;
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_vec_checker.sv
// Directed bench for comb_vec_checker: clean and faulted sweeps, latency,
// ignored start pulses and mid-sweep reset.
module tb_comb_vec_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance with SETTLE=2 (fault-injection sweeps)
    logic        start2;
    logic [3:0]  y2;
    logic        a2, b2, c2, d2, busy2, done2, fbvalid2;
    logic [15:0] truth2;
    logic [4:0]  mc2;
    logic [3:0]  fbv2;

    // Instance with SETTLE=1 (latency sweep)
    logic        start1;
    logic [3:0]  y1;
    logic        a1, b1, c1, d1, busy1, done1, fbvalid1;
    logic [15:0] truth1;
    logic [4:0]  mc1;
    logic [3:0]  fbv1;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    logic [3:0] vec2, vec1;
    assign vec2 = {a2, b2, c2, d2};
    assign vec1 = {a1, b1, c1, d1};

    // Function under test: Y = (A & ~B) | (C & D); truth table 16'h8F88.
    localparam logic [15:0] EXP_TRUTH = 16'h8F88;

    function automatic logic f(input logic [3:0] v);
        return (v[3] & ~v[2]) | (v[1] & v[0]);
    endfunction

    always_comb begin
        y2 = {4{f(vec2)}};
        case (mode)
            1: if (vec2 == 4'd5) y2[2] = ~y2[2];
            2: y2[3] = ~y2[3];
            3: if (vec2 == 4'hA) y2[1] = 1'bx;
            default: ;
        endcase
    end

    assign y1 = {4{f(vec1)}};

    comb_vec_checker #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .A(a2), .B(b2), .C(c2), .D(d2), .Y_in(y2),
        .busy(busy2), .done(done2), .truth(truth2), .mismatch_count(mc2),
        .first_bad_vec(fbv2), .first_bad_valid(fbvalid2)
    );

    comb_vec_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .C(c1), .D(d1), .Y_in(y1),
        .busy(busy1), .done(done1), .truth(truth1), .mismatch_count(mc1),
        .first_bad_vec(fbv1), .first_bad_valid(fbvalid1)
    );

    // Pulses start on dut2 and returns the edge index (accepting edge = 0) at which done appears.
    task automatic run_sweep(output int cyc);
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        @(negedge clk) start2 = 1'b0;
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy2);
        end
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL sweep_timeout: done not seen within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec2, busy2, done2, truth2, mc2, fbv2, fbvalid2} !== 32'd0) begin
            errors++;
            $display("FAIL reset_dut2: got %h want 0", {vec2, busy2, done2, truth2, mc2, fbv2, fbvalid2});
        end
        checks++;
        if ({vec1, busy1, done1, truth1, mc1, fbv1, fbvalid1} !== 32'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %h want 0", {vec1, busy1, done1, truth1, mc1, fbv1, fbvalid1});
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        int cyc;
        mode = 0;
        run_sweep(cyc);
        checks++;
        if (cyc != 48) begin
            errors++;
            $display("FAIL clean_latency: got %0d want 48", cyc);
        end
        checks++;
        if (truth2 !== EXP_TRUTH) begin
            errors++;
            $display("FAIL clean_truth: got %h want %h", truth2, EXP_TRUTH);
        end
        checks++;
        if (mc2 !== 5'd0 || fbvalid2 !== 1'b0) begin
            errors++;
            $display("FAIL clean_mismatch: got count %0d valid %b want 0 0", mc2, fbvalid2);
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0 || vec2 !== 4'hF) begin
            errors++;
            $display("FAIL clean_after_done: got done %b busy %b vec %h want 0 0 f", done2, busy2, vec2);
        end
    endtask

    task automatic test_single_fault();
        int cyc;
        mode = 1;
        run_sweep(cyc);
        checks++;
        if (mc2 !== 5'd1 || fbv2 !== 4'd5 || fbvalid2 !== 1'b1) begin
            errors++;
            $display("FAIL single_fault: got count %0d vec %h valid %b want 1 5 1", mc2, fbv2, fbvalid2);
        end
        checks++;
        if (truth2 !== EXP_TRUTH) begin
            errors++;
            $display("FAIL single_fault_truth: got %h want %h", truth2, EXP_TRUTH);
        end
    endtask

    task automatic test_all_fault();
        int cyc;
        mode = 2;
        run_sweep(cyc);
        checks++;
        if (mc2 !== 5'd16 || fbv2 !== 4'd0 || fbvalid2 !== 1'b1) begin
            errors++;
            $display("FAIL all_fault: got count %0d vec %h valid %b want 16 0 1", mc2, fbv2, fbvalid2);
        end
        @(negedge clk);
        checks++;
        if (mc2 !== 5'd16) begin
            errors++;
            $display("FAIL all_fault_hold: got count %0d want 16", mc2);
        end
    endtask

    task automatic test_x_input();
        int cyc;
        mode = 3;
        run_sweep(cyc);
        checks++;
        if (mc2 !== 5'd1 || fbv2 !== 4'hA || fbvalid2 !== 1'b1) begin
            errors++;
            $display("FAIL x_input: got count %0d vec %h valid %b want 1 a 1", mc2, fbv2, fbvalid2);
        end
        mode = 0;
    endtask

    task automatic test_latency_settle1();
        int done_at   = -1;
        int done_cnt  = 0;
        int seq_err   = 0;
        logic [3:0] exp_vec;
        logic idle_ok = 1'b1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        @(negedge clk) start1 = 1'b0;
        if (vec1 !== 4'd0) seq_err++;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            exp_vec = (cyc < 32) ? 4'(cyc / 2) : 4'hF;
            if (vec1 !== exp_vec) seq_err++;
            if (cyc >= 33 && (busy1 !== 1'b0 || done1 !== 1'b0)) idle_ok = 1'b0;
            start1 = (cyc == 10 || cyc == 32);
        end
        checks++;
        if (done_at != 32) begin
            errors++;
            $display("FAIL settle1_latency: got %0d want 32", done_at);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL settle1_done_width: got %0d cycles want 1", done_cnt);
        end
        checks++;
        if (seq_err != 0) begin
            errors++;
            $display("FAIL settle1_vector_seq: got %0d bad cycles want 0", seq_err);
        end
        checks++;
        if (idle_ok !== 1'b1) begin
            errors++;
            $display("FAIL settle1_start_in_done: got restart want idle");
        end
        checks++;
        if (truth1 !== EXP_TRUTH || mc1 !== 5'd0) begin
            errors++;
            $display("FAIL settle1_results: got truth %h count %0d want %h 0", truth1, mc1, EXP_TRUTH);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int wait_cyc = 0;
        int cyc;
        mode = 0;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        @(negedge clk) start2 = 1'b0;
        while (vec2 !== 4'd7 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (vec2 !== 4'd7) begin
            errors++;
            $display("FAIL midreset_reach_vec7: got %h want 7", vec2);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({vec2, busy2, done2, truth2, mc2, fbv2, fbvalid2} !== 32'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h want 0", {vec2, busy2, done2, truth2, mc2, fbv2, fbvalid2});
        end
        @(negedge clk) rst = 1'b0;
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: got done %b busy %b want 0 0", done2, busy2);
        end
        run_sweep(cyc);
        checks++;
        if (truth2 !== EXP_TRUTH || mc2 !== 5'd0 || fbvalid2 !== 1'b0 || cyc != 48) begin
            errors++;
            $display("FAIL midreset_resweep: got truth %h count %0d valid %b cyc %0d want %h 0 0 48",
                     truth2, mc2, fbvalid2, cyc, EXP_TRUTH);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_all_fault();
        test_x_input();
        test_latency_settle1();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
